xeng_window_sched: RTL
======================

# xeng_window_sched

Window scheduler that feeds the single-pol X-engine from a ping-pong pair of input buffers. It waits for a filled buffer and issues one full integration window of contiguous read addresses. It regenerates the X-engine's `sync`, `vld` and `mcnt` inputs aligned to the buffer's read data, then hands the buffer back to its producer. It sits between the packet-buffer write side and the X-engine top's `din/sync_in/vld/mcnt` ports.

## Interface
- `SERIAL_ACC_LEN_BITS`, 7: log2 serial accumulation length; must match the X-engine.
- `N_ANTS_BITS`, 6: log2 antenna count; must match the X-engine's `N_ANTS`.
- `MCNT_WIDTH`, 48: mcnt timestamp width.
- `RD_LATENCY`, 2: buffer read latency in cycles, from `rd_en`/`rd_addr` to data; must be ≥1.
- Derived: `ADDR_W = N_ANTS_BITS + SERIAL_ACC_LEN_BITS`, window length `W = 2^ADDR_W` cycles.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  allows new windows to start; never truncates a running window.
- `buf_rdy`  in  2  level per buffer; high = buffer full; held until release.
- `buf_mcnt0`, `buf_mcnt1`  in  MCNT_WIDTH  timestamp of buffer 0/1, stable while `buf_rdy[b]`.
- `buf_release`  out  2  one-cycle pulse; buffer b fully read.
- `rd_en`  out  1  buffer read strobe.
- `rd_sel`  out  1  buffer being read.
- `rd_addr`  out  ADDR_W  read address.
- `xeng_sync`  out  1  pulse on first data cycle of each window.
- `xeng_vld`  out  1  high for every data cycle of a window.
- `xeng_mcnt`  out  MCNT_WIDTH  mcnt of the window currently presented.
- `busy`  out  1  state is RUN.
- `win_count`  out  32  completed windows; wraps.

## Operation
- The state machine has two states, IDLE and RUN. An internal `next_sel` selects which buffer is served next; it resets to 0.
- Buffers are served in strict alternation 0,1,0,1…
  - If only the non-`next_sel` buffer is ready, the block waits.
  - There is no priority logic.
- IDLE → RUN: on any edge where `enable & buf_rdy[next_sel]` is true.
  - Latch `rd_sel <= next_sel`.
  - Latch the mcnt of that buffer.
  - Set `rd_addr <= 0`.
  - Set `rd_en <= 1`.
- RUN: `rd_en` stays high and `rd_addr` increments by 1 per cycle. `enable` is ignored in RUN.
- End of window: on the edge closing the cycle where `rd_addr == W-1`:
  - Pulse `buf_release[rd_sel]` for the next cycle.
  - Increment `win_count`.
  - Toggle `next_sel`.
- Back-to-back: if `enable & buf_rdy[~rd_sel]` on that same edge:
  - Stay in RUN and switch `rd_sel`.
  - Wrap `rd_addr` to 0 and latch the new mcnt.
  - `rd_en` stays high with no gap.
  - Otherwise go to IDLE with `rd_en <= 0`.
- `buf_rdy[b]` is don't-care during the cycle `buf_release[b]` is high. The producer drops it within 1 cycle after release.
- Output alignment: `xeng_vld` is `rd_en` delayed by RD_LATENCY.
  - `xeng_sync` is the "`rd_addr==0 & rd_en`" strobe delayed by RD_LATENCY.
  - `xeng_mcnt` takes the latched mcnt through the same delay; it updates only with `xeng_sync` and holds otherwise.
- The block does no arithmetic beyond the address counter (which wraps at W) and `win_count` (mod 2^32).

## Timing
- Reset values: every output is 0, `next_sel`=0, state IDLE, all delay-pipe stages cleared.
- Reset mid-window:
  - The window aborts immediately.
  - No `buf_release` is issued.
  - Delayed `xeng_vld`/`xeng_sync` are cleared.
  - Service restarts at buffer 0.
- Start latency: `buf_rdy` sampled at edge c gives `rd_en` high from cycle c+1. `xeng_vld` and `xeng_sync` go high at c+1+RD_LATENCY.
- A window issues exactly W consecutive `rd_en` cycles: c+1 … c+W. `buf_release` is high at c+W+1.
- Back-to-back windows:
  - `xeng_vld` is continuous.
  - `xeng_sync` period is exactly W.
  - The next window's address 0 is issued at c+W+1, the same cycle as the release.
- Minimum idle gap when not back-to-back is 1 cycle: the IDLE evaluation edge.
- `enable` falling mid-window: the window completes and releases normally, and no new window starts.

## Test plan
Test configuration: `SERIAL_ACC_LEN_BITS`=2, `N_ANTS_BITS`=2 (W=16), `RD_LATENCY`=2.
- Single window: `buf_rdy`=01 with mcnt0=0x5, sampled at edge 10.
  - `rd_en` high in cycles 11–26, `rd_addr` 0..15.
  - `xeng_sync` at 13, `xeng_vld` 13–28, `xeng_mcnt`=0x5 from 13.
  - `buf_release`=01 at 27, `win_count`=1.
- Back-to-back: both buffers ready, mcnt 0x5/0x6.
  - `rd_en` high for 32 contiguous cycles, `rd_sel` flips at cycle 27.
  - `xeng_sync` at 13 and 29, with `xeng_mcnt` 0x5 then 0x6.
  - Releases: 01 at 27, 10 at 43.
- Strict order: only `buf_rdy[1]` high after reset → no `rd_en` for 100 cycles. Raise `buf_rdy[0]` → buffer 0 is served first, then buffer 1 back-to-back.
- Enable drop: deassert `enable` at `rd_addr`=5 → that window still runs all 16 reads and releases. No further window starts although the other buffer is ready.
- Reset mid-window: assert `rst_n`=0 at `rd_addr`=7.
  - All outputs 0 asynchronously, no release pulse.
  - After reset, with `buf_rdy`=11, buffer 0 is re-read from address 0.
- Wrap: preload-free run of 2^32 windows is impractical. Force `win_count` near its maximum and check it wraps 0xFFFFFFFF→0 on the next release.

Source files
------------

// File: rtl/xeng_window_sched.sv
// Window scheduler: serves a ping-pong buffer pair in strict alternation, issuing one
// integration window of reads and regenerating X-engine sync/vld/mcnt aligned to read data.
module xeng_window_sched #(
  parameter int unsigned SERIAL_ACC_LEN_BITS = 7,
  parameter int unsigned N_ANTS_BITS         = 6,
  parameter int unsigned MCNT_WIDTH          = 48,
  parameter int unsigned RD_LATENCY          = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        enable,
  input  logic [1:0]                                  buf_rdy,
  input  logic [MCNT_WIDTH-1:0]                       buf_mcnt0,
  input  logic [MCNT_WIDTH-1:0]                       buf_mcnt1,
  output logic [1:0]                                  buf_release,
  output logic                                        rd_en,
  output logic                                        rd_sel,
  output logic [N_ANTS_BITS+SERIAL_ACC_LEN_BITS-1:0]  rd_addr,
  output logic                                        xeng_sync,
  output logic                                        xeng_vld,
  output logic [MCNT_WIDTH-1:0]                       xeng_mcnt,
  output logic                                        busy,
  output logic [31:0]                                 win_count
);

  localparam int unsigned ADDR_W = N_ANTS_BITS + SERIAL_ACC_LEN_BITS;
  localparam int unsigned CNT_W  = 32;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    next_sel_q, next_sel_d;
  logic                    rd_sel_q, rd_sel_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic [MCNT_WIDTH-1:0]   mcnt_q, mcnt_d;
  logic [1:0]              buf_release_q, buf_release_d;
  logic [CNT_W-1:0]        win_count_q, win_count_d;
  logic                    busy_q, busy_d;

  logic [RD_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0]   sync_pipe_q, sync_pipe_d;
  logic [MCNT_WIDTH-1:0]   mcnt_pipe_q [RD_LATENCY];
  logic [MCNT_WIDTH-1:0]   mcnt_pipe_d [RD_LATENCY];

  logic                    cand_sel_c;
  logic [MCNT_WIDTH-1:0]   cand_mcnt_c;
  logic                    sync_src_c;

  // Candidate buffer for the next window: next_sel when idle, the other buffer at window end.
  assign cand_sel_c  = (state_q == RUN) ? ~rd_sel_q : next_sel_q;
  assign cand_mcnt_c = cand_sel_c ? buf_mcnt1 : buf_mcnt0;
  assign sync_src_c  = rd_en_q && (rd_addr_q == '0);

  // Window sequencing
  always_comb begin
    state_d       = state_q;
    next_sel_d    = next_sel_q;
    rd_sel_d      = rd_sel_q;
    rd_en_d       = rd_en_q;
    rd_addr_d     = rd_addr_q;
    mcnt_d        = mcnt_q;
    buf_release_d = 2'b00;
    win_count_d   = win_count_q;

    unique case (state_q)
      IDLE: begin
        if (enable && buf_rdy[cand_sel_c]) begin
          state_d   = RUN;
          rd_sel_d  = cand_sel_c;
          mcnt_d    = cand_mcnt_c;
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
        end
      end
      RUN: begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (rd_addr_q == LAST_ADDR) begin
          buf_release_d[rd_sel_q] = 1'b1;
          win_count_d             = win_count_q + CNT_W'(1);
          next_sel_d              = ~next_sel_q;
          if (enable && buf_rdy[cand_sel_c]) begin
            rd_sel_d = cand_sel_c;
            mcnt_d   = cand_mcnt_c;
          end else begin
            state_d = IDLE;
            rd_en_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rd_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // Read-latency alignment; mcnt stages only advance alongside their sync strobe
  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    sync_pipe_d    = sync_pipe_q;
    mcnt_pipe_d    = mcnt_pipe_q;
    vld_pipe_d[0]  = rd_en_q;
    sync_pipe_d[0] = sync_src_c;
    mcnt_pipe_d[0] = sync_src_c ? mcnt_q : mcnt_pipe_q[0];
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      sync_pipe_d[i] = sync_pipe_q[i-1];
      mcnt_pipe_d[i] = sync_pipe_q[i-1] ? mcnt_pipe_q[i-1] : mcnt_pipe_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      next_sel_q    <= 1'b0;
      rd_sel_q      <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      mcnt_q        <= '0;
      buf_release_q <= 2'b00;
      win_count_q   <= '0;
      busy_q        <= 1'b0;
      vld_pipe_q    <= '0;
      sync_pipe_q   <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        mcnt_pipe_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      next_sel_q    <= next_sel_d;
      rd_sel_q      <= rd_sel_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      mcnt_q        <= mcnt_d;
      buf_release_q <= buf_release_d;
      win_count_q   <= win_count_d;
      busy_q        <= busy_d;
      vld_pipe_q    <= vld_pipe_d;
      sync_pipe_q   <= sync_pipe_d;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        mcnt_pipe_q[i] <= mcnt_pipe_d[i];
      end
    end
  end

  assign buf_release = buf_release_q;
  assign rd_en       = rd_en_q;
  assign rd_sel      = rd_sel_q;
  assign rd_addr     = rd_addr_q;
  assign xeng_vld    = vld_pipe_q[RD_LATENCY-1];
  assign xeng_sync   = sync_pipe_q[RD_LATENCY-1];
  assign xeng_mcnt   = mcnt_pipe_q[RD_LATENCY-1];
  assign busy        = busy_q;
  assign win_count   = win_count_q;

endmodule
